circle_draw_param: RTL
======================

Name: circle_draw_param

Overview:
- Parametrised successor to the team's midpoint circle plotter, generalised in screen size, coordinate width, radius width and colour width.
- Adds a filled-disc mode alongside outline mode.
- Adds signed, overflow-safe coordinate arithmetic with explicit clipping, plus registered VGA outputs with defined latency.
- Sits between the task FSM and the VGA adapter; drives one plot request per cycle.

Parameters:
- SCR_W, 160, screen width in pixels.
- SCR_H, 120, screen height in pixels.
- X_W, 8, vga_x / centre_x width.
- Y_W, 7, vga_y / centre_y width.
- R_W, 8, radius width.
- COL_W, 3, colour width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  level request; must stay high until done is seen
- fill  in  1  0 = outline, 1 = filled disc; latched at start
- colour  in  COL_W  pixel colour; latched at start
- centre_x  in  X_W  centre x; latched at start
- centre_y  in  Y_W  centre y; latched at start
- radius  in  R_W  radius; latched at start
- done  out  1  drawing complete; held while start stays high
- vga_x  out  X_W  plot x (registered)
- vga_y  out  Y_W  plot y (registered)
- vga_colour  out  COL_W  plot colour (registered)
- vga_plot  out  1  write strobe (registered)

Behaviour:
- Reset: state IDLE; done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
- States: IDLE, OCT (sub-index 0..7), SPAN (sub-index 0..3, x-walker), STEP, DONE.
- IDLE, start=1 at edge E0:
  - Latch all inputs.
  - Set oy=0, ox=radius, crit=1-radius.
  - Go to OCT (fill=0) or SPAN (fill=1).
- First pixel appears on outputs after edge E1.
- Internal arithmetic:
  - Coordinates signed, max(X_W,Y_W)+2 bits.
  - crit signed, R_W+3 bits; no truncation anywhere.
- Outline mode, one cycle per point, order OCT0..7:
  - (cx+ox,cy+oy), (cx+oy,cy+ox), (cx-oy,cy+ox), (cx-ox,cy+oy)
  - (cx-ox,cy-oy), (cx-oy,cy-ox), (cx+oy,cy-ox), (cx+ox,cy-oy)
- Fill mode, four spans per step, x ascending, one pixel per cycle:
  - row cy+oy, x cx-ox..cx+ox
  - row cy-oy, x cx-ox..cx+ox
  - row cy+ox, x cx-oy..cx+oy
  - row cy-ox, x cx-oy..cx+oy
- Duplicate points and rows are emitted, not suppressed, so cycle count is deterministic.
- Clipping:
  - vga_plot=1 only if 0<=x<SCR_W and 0<=y<SCR_H.
  - Off-screen pixels still consume their cycle with vga_plot=0.
  - vga_x/vga_y carry the low bits of the signed value.
- STEP is folded into the last pixel cycle of a step; no extra cycle.
  - oy' = oy+1.
  - If crit<=0: crit' = crit + 2*oy' + 1.
  - Else: ox' = ox-1; crit' = crit + 2*(oy'-ox') + 1.
  - If oy' > ox', go to DONE; else start the next step.
- DONE:
  - vga_plot=0, done=1 from the edge after the last pixel.
  - Stays in DONE while start=1; start=0 returns to IDLE with done=0 next edge.
  - New inputs are accepted only via IDLE.
- Abort: start=0 in OCT or SPAN → next edge IDLE, vga_plot=0, done never asserted.
- rst_n low mid-draw: immediate return to reset values; no residual plots.
- radius=0 is legal: one step at the centre, then DONE.
- vga_colour is updated only on plotted cycles.

Decomposition:
- circle_pkg holds:
  - state enum;
  - MODE_OUTLINE and MODE_FILL constants;
  - coordinate and crit width helper localparams derived from X_W, Y_W, R_W.
- One sub-module, span_walker:
  - loads x0, x1, y;
  - emits one x per cycle;
  - pulses last on x==x1.
- Top level owns the midpoint FSM, the octant mux and clipping.

Test Plan:
- Outline r=0 at (80,60) → 8 cycles of vga_plot=1 at (80,60), then done=1; 9 cycles from E1 to done.
- Outline r=1 at (10,10):
  - → 16 plot cycles: (11,10),(10,11),(10,11),(9,10),(9,10),(10,9),(10,9),(11,10)
  - then (11,11)x2,(9,11)x2,(9,9)x2,(11,9)x2; then done.
- Fill r=1 at (50,50) → 20 pixel cycles covering exactly the 3x3 block 49..51 × 49..51; done on cycle 21.
- Clipping, outline r=5 at (2,2) → every emitted point with x<0 or y<0 has vga_plot=0; total cycle count equals the unclipped r=5 count.
- Abort: drop start during the 4th pixel of r=20 → next edge IDLE, vga_plot=0, done stays 0; restart draws the full circle.
- Handshake: hold start after done → done stays 1, no plots; start low → done=0 next edge; rst_n pulse mid-fill → all outputs 0 immediately.

Source files
------------

// File: rtl/circle_pkg.sv
// Shared types and width helpers for the parametrised circle plotter.
// Exports: state_e (FSM states), MODE_OUTLINE/MODE_FILL, and width
//          functions for coordinates, radius offsets and the crit term.
package circle_pkg;

   // The per-step update is folded into the last pixel cycle of each step,
   // so no separate step state exists.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OCT,
      ST_SPAN,
      ST_DONE
   } state_e;

   localparam logic MODE_OUTLINE = 1'b0;
   localparam logic MODE_FILL    = 1'b1;

   // Signed coordinate width: two bits above the widest operand, so that
   // centre +/- radius can neither wrap nor lose its sign.
   function automatic int coord_w(input int xw, input int yw, input int rw);
      int m;
      m = (xw > yw) ? xw : yw;
      if (rw > m) m = rw;
      return m + 2;
   endfunction

   // Signed width of the ox/oy offsets (ox reaches -1 on the final step).
   function automatic int ofs_w(input int rw);
      return rw + 2;
   endfunction

   // Signed width of the midpoint decision variable.
   function automatic int crit_w(input int rw);
      return rw + 3;
   endfunction

endpackage

// File: rtl/span_walker.sv
// Horizontal span walker: loads x0/x1/y, presents one x per cycle.
// Ports: load_i (takes x0_i/x1_i/y_i), adv_i (x+1), x_o/y_o current pixel,
//        last_o high while x_o == x1. Latency: x0 visible the cycle after load_i.
module span_walker #(
   parameter int W = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_i,
   input  logic                adv_i,
   input  logic signed [W-1:0] x0_i,
   input  logic signed [W-1:0] x1_i,
   input  logic signed [W-1:0] y_i,
   output logic signed [W-1:0] x_o,
   output logic signed [W-1:0] y_o,
   output logic                last_o
);

   logic signed [W-1:0] x_q, x_d, x1_q, x1_d, y_q, y_d;

   always_comb begin
      x_d  = x_q;
      x1_d = x1_q;
      y_d  = y_q;
      if (load_i) begin
         x_d  = x0_i;
         x1_d = x1_i;
         y_d  = y_i;
      end else if (adv_i) begin
         x_d = x_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q  <= '0;
         x1_q <= '0;
         y_q  <= '0;
      end else begin
         x_q  <= x_d;
         x1_q <= x1_d;
         y_q  <= y_d;
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign last_o = (x_q == x1_q);

endmodule

// File: rtl/circle_draw_param.sv
// Midpoint circle / filled-disc plotter with clipping and registered VGA outputs.
// Ports: start (level, held until done), fill/colour/centre/radius latched at start;
//        vga_* registered, first pixel one cycle after start is accepted; done held while start.
module circle_draw_param
   import circle_pkg::*;
#(
   parameter int SCR_W = 160,
   parameter int SCR_H = 120,
   parameter int X_W   = 8,
   parameter int Y_W   = 7,
   parameter int R_W   = 8,
   parameter int COL_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             fill,
   input  logic [COL_W-1:0] colour,
   input  logic [X_W-1:0]   centre_x,
   input  logic [Y_W-1:0]   centre_y,
   input  logic [R_W-1:0]   radius,
   output logic             done,
   output logic [X_W-1:0]   vga_x,
   output logic [Y_W-1:0]   vga_y,
   output logic [COL_W-1:0] vga_colour,
   output logic             vga_plot
);

   localparam int CW  = coord_w(X_W, Y_W, R_W);
   localparam int OW  = ofs_w(R_W);
   localparam int CRW = crit_w(R_W);
   localparam logic signed [CW-1:0] SCR_W_S = CW'(SCR_W);
   localparam logic signed [CW-1:0] SCR_H_S = CW'(SCR_H);

   state_e                  state_q, state_d;
   logic [2:0]              sub_q, sub_d;
   logic signed [OW-1:0]    ox_q, ox_d, oy_q, oy_d, ox_n, oy_n;
   logic signed [CRW-1:0]   crit_q, crit_d, crit_n;
   logic [X_W-1:0]          cx_q, cx_d;
   logic [Y_W-1:0]          cy_q, cy_d;
   logic [COL_W-1:0]        colour_q, colour_d;

   logic                    active, step_end, span_load, span_adv, span_last;
   logic                    crit_le0, on_scr, done_d;
   logic signed [CW-1:0]    cxs, cys, oxs, oys, oct_x, oct_y, pix_x, pix_y;
   logic signed [CW-1:0]    span_x, span_y;
   logic signed [CW-1:0]    nxs, nys, noxs, noys, ld_x0, ld_x1, ld_y;

   logic                    done_q, vga_plot_q;
   logic [X_W-1:0]          vga_x_q;
   logic [Y_W-1:0]          vga_y_q;
   logic [COL_W-1:0]        vga_colour_q;

   assign cxs = signed'(CW'(cx_q));
   assign cys = signed'(CW'(cy_q));
   assign oxs = CW'(ox_q);
   assign oys = CW'(oy_q);

   // Midpoint step, applied on the last pixel cycle of every step.
   assign crit_le0 = crit_q[CRW-1] || (crit_q == '0);
   assign oy_n     = oy_q + OW'(1);
   assign ox_n     = crit_le0 ? ox_q : ox_q - OW'(1);
   assign crit_n   = crit_le0 ? crit_q + CRW'(oy_n) + CRW'(oy_n) + CRW'(1)
                              : crit_q + CRW'(oy_n) + CRW'(oy_n)
                                       - CRW'(ox_n) - CRW'(ox_n) + CRW'(1);

   // Octant mux for outline mode.
   always_comb begin
      oct_x = cxs + oxs;
      oct_y = cys + oys;
      unique case (sub_q)
         3'd0: begin oct_x = cxs + oxs; oct_y = cys + oys; end
         3'd1: begin oct_x = cxs + oys; oct_y = cys + oxs; end
         3'd2: begin oct_x = cxs - oys; oct_y = cys + oxs; end
         3'd3: begin oct_x = cxs - oxs; oct_y = cys + oys; end
         3'd4: begin oct_x = cxs - oxs; oct_y = cys - oys; end
         3'd5: begin oct_x = cxs - oys; oct_y = cys - oxs; end
         3'd6: begin oct_x = cxs + oys; oct_y = cys - oxs; end
         3'd7: begin oct_x = cxs + oxs; oct_y = cys - oys; end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      sub_d     = sub_q;
      ox_d      = ox_q;
      oy_d      = oy_q;
      crit_d    = crit_q;
      cx_d      = cx_q;
      cy_d      = cy_q;
      colour_d  = colour_q;
      pix_x     = '0;
      pix_y     = '0;
      active    = 1'b0;
      step_end  = 1'b0;
      span_load = 1'b0;
      span_adv  = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               cx_d     = centre_x;
               cy_d     = centre_y;
               colour_d = colour;
               ox_d     = signed'(OW'(radius));
               oy_d     = '0;
               crit_d   = CRW'(1) - signed'(CRW'(radius));
               sub_d    = '0;
               if (fill == MODE_FILL) begin
                  state_d   = ST_SPAN;
                  span_load = 1'b1;
               end else begin
                  state_d = ST_OCT;
               end
            end
         end
         ST_OCT: begin
            if (!start) begin
               state_d = ST_IDLE;
            end else begin
               active = 1'b1;
               pix_x  = oct_x;
               pix_y  = oct_y;
               if (sub_q == 3'd7) step_end = 1'b1;
               else               sub_d    = sub_q + 3'd1;
            end
         end
         ST_SPAN: begin
            if (!start) begin
               state_d = ST_IDLE;
            end else begin
               active = 1'b1;
               pix_x  = span_x;
               pix_y  = span_y;
               if (span_last) begin
                  span_load = 1'b1;
                  if (sub_q == 3'd3) step_end = 1'b1;
                  else               sub_d    = sub_q + 3'd1;
               end else begin
                  span_adv = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (start) done_d  = 1'b1;
            else       state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (step_end) begin
         oy_d   = oy_n;
         ox_d   = ox_n;
         crit_d = crit_n;
         sub_d  = '0;
         if (oy_n > ox_n) state_d = ST_DONE;
      end
   end

   // The walker is always loaded with the span selected by the *next*
   // register values, so the first pixel of each span is ready on time
   // even across a step boundary.
   assign nxs  = signed'(CW'(cx_d));
   assign nys  = signed'(CW'(cy_d));
   assign noxs = CW'(ox_d);
   assign noys = CW'(oy_d);

   always_comb begin
      ld_x0 = nxs - noxs;
      ld_x1 = nxs + noxs;
      ld_y  = nys + noys;
      unique case (sub_d[1:0])
         2'd0: begin ld_x0 = nxs - noxs; ld_x1 = nxs + noxs; ld_y = nys + noys; end
         2'd1: begin ld_x0 = nxs - noxs; ld_x1 = nxs + noxs; ld_y = nys - noys; end
         2'd2: begin ld_x0 = nxs - noys; ld_x1 = nxs + noys; ld_y = nys + noxs; end
         2'd3: begin ld_x0 = nxs - noys; ld_x1 = nxs + noys; ld_y = nys - noxs; end
         default: ;
      endcase
   end

   span_walker #(.W(CW)) u_span (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (span_load),
      .adv_i  (span_adv),
      .x0_i   (ld_x0),
      .x1_i   (ld_x1),
      .y_i    (ld_y),
      .x_o    (span_x),
      .y_o    (span_y),
      .last_o (span_last)
   );

   assign on_scr = !pix_x[CW-1] && (pix_x < SCR_W_S) &&
                   !pix_y[CW-1] && (pix_y < SCR_H_S);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         sub_q        <= '0;
         ox_q         <= '0;
         oy_q         <= '0;
         crit_q       <= '0;
         cx_q         <= '0;
         cy_q         <= '0;
         colour_q     <= '0;
         done_q       <= 1'b0;
         vga_plot_q   <= 1'b0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
      end else begin
         state_q    <= state_d;
         sub_q      <= sub_d;
         ox_q       <= ox_d;
         oy_q       <= oy_d;
         crit_q     <= crit_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         colour_q   <= colour_d;
         done_q     <= done_d;
         vga_plot_q <= active && on_scr;
         // Off-screen pixels still present their wrapped low bits.
         if (active) begin
            vga_x_q <= pix_x[X_W-1:0];
            vga_y_q <= pix_y[Y_W-1:0];
         end
         if (active && on_scr) vga_colour_q <= colour_q;
      end
   end

   assign done       = done_q;
   assign vga_plot   = vga_plot_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;

endmodule
